// File: rtl/result_sram_reader_if.sv
// Beat stream interface of the result SRAM reader.
// master drives valid/data/last; slave returns ready.
interface result_sram_reader_if #(
   parameter int OUT_W = 32
) ();
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/result_sram_reader.sv
// Unloads result SRAM banks a, b, c as a 32-bit beat stream.
// Optional macro RESULT_RD_PREFETCH_EN prefetches the next word for a gapless stream.
module result_sram_reader #(
   parameter int ADDR_W   = 6,
   parameter int DEPTH    = 64,
   parameter int DATA_W   = 128,
   parameter int OUT_W    = 32,
   parameter int NUM_BANK = 3
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 start,
   output logic [ADDR_W-1:0]    sram_raddr_a,
   output logic [ADDR_W-1:0]    sram_raddr_b,
   output logic [ADDR_W-1:0]    sram_raddr_c,
   input  logic [DATA_W-1:0]    sram_rdata_a,
   input  logic [DATA_W-1:0]    sram_rdata_b,
   input  logic [DATA_W-1:0]    sram_rdata_c,
   result_sram_reader_if.master stream,
   output logic                 busy,
   output logic                 done
);

   localparam int BEATS  = DATA_W / OUT_W;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BANK_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [BANK_W-1:0] BANK_LAST = BANK_W'(NUM_BANK - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      SEND,
      DONE
   } state_t;

   state_t              state;
   logic [BANK_W-1:0]   bank;
   logic [ADDR_W-1:0]   addr;
   logic [BEAT_W-1:0]   beat;
   logic [DATA_W-1:0]   shift;
   logic                fin;
   logic                valid_q;
   logic                last_q;
   logic [OUT_W-1:0]    data_q;

   logic [DATA_W-1:0]   sel_data;
   logic                cur_fin;
   logic [ADDR_W-1:0]   nxt_addr;
   logic [BANK_W-1:0]   nxt_bank;
   logic [BEAT_W-1:0]   beat_nx;
   logic                fire;

`ifdef RESULT_RD_PREFETCH_EN
   logic [DATA_W-1:0]   pend;
   logic                pend_vld;
   logic                pf_iss;
   logic                pf_rd;
`endif

   assign sram_raddr_a     = addr;
   assign sram_raddr_b     = addr;
   assign sram_raddr_c     = addr;
   assign stream.out_valid = valid_q;
   assign stream.out_data  = data_q;
   assign stream.out_last  = last_q;

   assign cur_fin  = (bank == BANK_LAST) && (addr == ADDR_LAST);
   assign nxt_addr = (addr == ADDR_LAST) ? '0 : addr + ADDR_W'(1);
   assign nxt_bank = (addr == ADDR_LAST) ? bank + BANK_W'(1) : bank;
   assign beat_nx  = beat + BEAT_W'(1);
   assign fire     = valid_q && stream.out_ready;

   // Read data mux steered by the registered bank counter.
   always_comb begin
      sel_data = sram_rdata_a;
      case (bank)
         BANK_W'(1): sel_data = sram_rdata_b;
         BANK_W'(2): sel_data = sram_rdata_c;
         default:    sel_data = sram_rdata_a;
      endcase
   end

   // Unload sequencer: address walk, word capture and beat serialisation.
   always_ff @(posedge clk) begin
      if (srst) begin
         state   <= IDLE;
         bank    <= '0;
         addr    <= '0;
         beat    <= '0;
         shift   <= '0;
         fin     <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         data_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
`ifdef RESULT_RD_PREFETCH_EN
         pend     <= '0;
         pend_vld <= 1'b0;
         pf_iss   <= 1'b0;
         pf_rd    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef RESULT_RD_PREFETCH_EN
         // prefetched address is presented one cycle, data lands the next
         pf_iss <= 1'b0;
         pf_rd  <= pf_iss;
         if (pf_rd) begin
            pend     <= sel_data;
            pend_vld <= 1'b1;
         end
`endif
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ISSUE;
                  busy  <= 1'b1;
                  bank  <= '0;
                  addr  <= '0;
               end
            end

            ISSUE: begin
               state <= WAIT;
            end

            WAIT: begin
               state   <= SEND;
               shift   <= sel_data;
               beat    <= '0;
               fin     <= cur_fin;
               valid_q <= 1'b1;
               data_q  <= sel_data[OUT_W-1:0];
               last_q  <= cur_fin && (BEAT_LAST == '0);
`ifdef RESULT_RD_PREFETCH_EN
               pend_vld <= 1'b0;
               pf_rd    <= 1'b0;
               if (!cur_fin) begin
                  addr   <= nxt_addr;
                  bank   <= nxt_bank;
                  pf_iss <= 1'b1;
               end
`endif
            end

            SEND: begin
               if (fire) begin
                  if (beat != BEAT_LAST) begin
                     beat   <= beat_nx;
                     data_q <= shift[OUT_W*beat_nx +: OUT_W];
                     last_q <= fin && (beat_nx == BEAT_LAST);
                  end else if (fin) begin
                     state   <= DONE;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     data_q  <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
`ifdef RESULT_RD_PREFETCH_EN
                     if (pend_vld) begin
                        // pending word is the one at bank/addr
                        shift    <= pend;
                        beat     <= '0;
                        fin      <= cur_fin;
                        data_q   <= pend[OUT_W-1:0];
                        last_q   <= cur_fin && (BEAT_LAST == '0);
                        pend_vld <= 1'b0;
                        if (!cur_fin) begin
                           addr   <= nxt_addr;
                           bank   <= nxt_bank;
                           pf_iss <= 1'b1;
                        end
                     end else begin
                        // address already issued; pick data up in WAIT
                        state   <= WAIT;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        data_q  <= '0;
                     end
`else
                     state   <= ISSUE;
                     addr    <= nxt_addr;
                     bank    <= nxt_bank;
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     data_q  <= '0;
`endif
                  end
               end
            end

            DONE: begin
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_result_sram_reader.sv
// Directed bench for result_sram_reader: full unload, backpressure,
// ignored start, mid-unload reset and a two-word-per-bank build.
module tb_result_sram_reader;

  localparam int AW = 6;
  localparam int DW = 128;
  localparam int OW = 32;

`ifdef RESULT_RD_PREFETCH_EN
  localparam int T64 = 770;
  localparam int T2  = 26;
`else
  localparam int T64 = 1152;
  localparam int T2  = 36;
`endif

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic ready = 1'b0;

  logic [AW-1:0] ra0, rb0, rc0, ra1, rb1, rc1;
  logic [DW-1:0] da0, db0, dc0, da1, db1, dc1;
  logic busy0, done0, busy1, done1;

  logic          ov, ol, ob, odn;
  logic [OW-1:0] od;
  logic [AW-1:0] oa, obk, oc;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  result_sram_reader_if #(.OUT_W(OW)) s0 ();
  result_sram_reader_if #(.OUT_W(OW)) s1 ();

  assign s0.out_ready = ready;
  assign s1.out_ready = ready;

  result_sram_reader #(
    .ADDR_W(AW), .DEPTH(64), .DATA_W(DW),
    .OUT_W(OW), .NUM_BANK(3)
  ) dut0 (
    .clk(clk), .srst(srst), .start(start0),
    .sram_raddr_a(ra0), .sram_raddr_b(rb0),
    .sram_raddr_c(rc0),
    .sram_rdata_a(da0), .sram_rdata_b(db0),
    .sram_rdata_c(dc0),
    .stream(s0.master), .busy(busy0), .done(done0)
  );

  result_sram_reader #(
    .ADDR_W(AW), .DEPTH(2), .DATA_W(DW),
    .OUT_W(OW), .NUM_BANK(3)
  ) dut1 (
    .clk(clk), .srst(srst), .start(start1),
    .sram_raddr_a(ra1), .sram_raddr_b(rb1),
    .sram_raddr_c(rc1),
    .sram_rdata_a(da1), .sram_rdata_b(db1),
    .sram_rdata_c(dc1),
    .stream(s1.master), .busy(busy1), .done(done1)
  );

  function automatic logic [DW-1:0] word(
    input int b, input logic [AW-1:0] i);
    logic [31:0] t;
    t = 32'((b + 1) << 24) | 32'(i);
    return {t, t + 32'd1, t + 32'd2, t + 32'd3};
  endfunction

  always @(posedge clk) begin
    da0 <= word(0, ra0);
    db0 <= word(1, rb0);
    dc0 <= word(2, rc0);
    da1 <= word(0, ra1);
    db1 <= word(1, rb1);
    dc1 <= word(2, rc1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      ov = s0.out_valid; od = s0.out_data;
      ol = s0.out_last;
      ob = busy0; odn = done0;
      oa = ra0; obk = rb0; oc = rc0;
    end else begin
      ov = s1.out_valid; od = s1.out_data;
      ol = s1.out_last;
      ob = busy1; odn = done1;
      oa = ra1; obk = rb1; oc = rc1;
    end
  endtask

  task automatic check_zero(input int d);
    sample(d);
    chk("zero_valid", ov, 1'b0);
    chk("zero_last", ol, 1'b0);
    chk("zero_data", od, 32'd0);
    chk("zero_busy", ob, 1'b0);
    chk("zero_done", odn, 1'b0);
    chk("zero_raddr_a", oa, 6'd0);
    chk("zero_raddr_b", obk, 6'd0);
    chk("zero_raddr_c", oc, 6'd0);
  endtask

  task automatic run(input int d, input int pct,
                     input int rs_beat, input int rst_beat,
                     input int t_exp);
    int depth, nbeats, beats, cyc, dones;
    int t_last, t_done;
    int w, s, b, i;
    logic pv, pl;
    logic [31:0] pd, expv;
    depth = (d == 0) ? 64 : 2;
    nbeats = depth * 3 * 4;
    beats = 0; cyc = 0; dones = 0;
    t_last = -1; t_done = -1;
    pv = 1'b0; pl = 1'b0; pd = '0;
    @(negedge clk);
    if (d == 0) start0 = 1'b1; else start1 = 1'b1;
    while (dones == 0 && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      start0 = 1'b0;
      start1 = 1'b0;
      ready = (int'($urandom_range(99)) < pct);
      sample(d);
      if (rst_beat >= 0 && beats == rst_beat) begin
        srst = 1'b1;
        @(negedge clk);
        check_zero(d);
        srst = 1'b0;
        return;
      end
      if (cyc == 1) chk("busy_rise", ob, 1'b1);
      if (cyc == 2) chk("no_early_valid", ov, 1'b0);
      if (cyc == 3 && pct == 100)
        chk("first_valid", ov, 1'b1);
      if (rs_beat >= 0 && beats == rs_beat) begin
        if (d == 0) start0 = 1'b1;
        else start1 = 1'b1;
      end
      if (pv) begin
        chk("hold_valid", ov, 1'b1);
        chk("hold_data", od, pd);
        chk("hold_last", ol, pl);
      end
      if (odn) begin
        dones++;
        t_done = cyc;
        chk("busy_at_done", ob, 1'b0);
        if (rs_beat >= 0) begin
          if (d == 0) start0 = 1'b1;
          else start1 = 1'b1;
        end
      end
      if (ov && ready) begin
        w = beats / 4; s = beats % 4;
        b = w / depth; i = w % depth;
        expv = 32'(((b + 1) << 24) | (i + 3 - s));
        chk("beat_data", od, expv);
        chk("beat_last", ol,
            logic'(beats == nbeats - 1));
        if (ol) t_last = cyc;
        beats++;
      end
      pv = ov && !ready;
      pd = od;
      pl = ol;
    end
    chk("done_seen", dones, 1);
    chk("beat_count", beats, nbeats);
    if (pct == 100) begin
      chk("t_last", t_last, t_exp);
      chk("t_done", t_done, t_last + 1);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    sample(d);
    chk("done_one_cycle", odn, 1'b0);
    chk("idle_after_done", ob, 1'b0);
    @(negedge clk);
    sample(d);
    chk("still_idle", ob, 1'b0);
    chk("no_second_done", odn, 1'b0);
  endtask

  initial begin
    srst = 1'b1;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    srst = 1'b0;
    run(0, 100, -1, -1, T64);
    run(0, 30, -1, -1, T64);
    run(0, 100, 100, -1, T64);
    run(0, 100, -1, 300, T64);
    run(0, 100, -1, -1, T64);
    run(1, 100, -1, -1, T2);
    run(1, 30, -1, -1, T2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
